banner_overlay: RTL and testbench
=================================

# banner_overlay

Parametrised, animated sprite-window generator for full-width text banners such as game-over, level-up and pause. It tracks the VGA pixel position and asserts a hit flag and a ROM address whenever the pixel falls inside the banner rectangle. Unlike a static overlay, it slides the banner in from above the screen, settles at a programmable centre and can blink. All motion advances once per frame. It sits between the VGA controller and the colour mapper, driving the banner ROM address.

## Interface
- WIDTH, 203: banner width in pixels (1..320).
- HEIGHT, 31: banner height in pixels (1..240).
- X_CENTER, 160: final horizontal centre.
- Y_CENTER, 100: final vertical centre.
- ADDR_W, 15: ROM address width. Must satisfy 2^ADDR_W >= WIDTH*HEIGHT; elaboration fails otherwise.
- SLIDE_STEP, 4: pixels moved down per frame. A value of 0 means no slide: the banner appears settled immediately.
- BLINK_FRAMES, 30: frames per blink half-period (>= 1).
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Show  in  1  level: banner requested.
- Blink_En  in  1  level: blink while settled.
- Frame_Tick  in  1  one-cycle pulse per frame, at vblank start.
- PixelX, PixelY  in  9 each  current pixel coordinate.
- is_obj  out  1  registered: pixel is inside the visible banner.
- Obj_address  out  ADDR_W  registered: ROM address DistX + DistY*WIDTH; 0 when is_obj is 0.
- Settled  out  1  registered: banner has reached its final position.

## Operation
- Constants:
  - X_POS = X_CENTER - WIDTH/2 (integer division).
  - Y_FINAL = Y_CENTER - HEIGHT/2.
  - Y_START = -HEIGHT.
  - Top coordinate Y_TOP is a 10-bit signed register.
- States:
  - HIDDEN: no hits. Y_TOP = Y_START, blink counter = 0, visible phase = 1.
  - SLIDING: on each Frame_Tick, Y_TOP += SLIDE_STEP, clamped to Y_FINAL. The tick that reaches Y_FINAL moves the FSM to SETTLED.
  - SETTLED: Settled = 1. If Blink_En, each Frame_Tick increments the blink counter. When the counter reaches BLINK_FRAMES-1, it wraps to 0 and the visible phase toggles. If Blink_En is 0, the counter is 0 and the phase is 1.
- Transitions:
  - HIDDEN to SLIDING when Show = 1, evaluated every cycle. If SLIDE_STEP = 0, the FSM goes directly to SETTLED with Y_TOP = Y_FINAL.
  - Any state to HIDDEN on the cycle Show = 0. Position and blink state reload their HIDDEN values.
- Simultaneous events:
  - Show rising together with Frame_Tick: enter SLIDING; the tick does not move the banner.
  - Blink_En falling mid-blink: phase returns to visible on the next cycle.
- Hit test, signed 10-bit compares:
  - Condition: X_POS <= PixelX < X_POS + WIDTH, and Y_TOP <= PixelY < Y_TOP + HEIGHT, and state != HIDDEN, and visible phase = 1.
  - Rows with negative screen Y never match. The partially visible banner is correctly clipped, and DistY = PixelY - Y_TOP stays in range 0..HEIGHT-1.
- Address arithmetic:
  - Computed at full product width, then truncated to ADDR_W.
  - Maximum value is WIDTH*HEIGHT - 1.

## Timing
- Reset (asynchronous): state HIDDEN, Y_TOP = Y_START, is_obj = 0, Obj_address = 0, Settled = 0, blink counter = 0, phase = 1.
- Pixel path latency is 1 cycle: is_obj and Obj_address correspond to the PixelX/PixelY sampled on the previous edge.
- Y_TOP and the blink phase change only on Frame_Tick edges, Show edges, or a Blink_En fall. Position is therefore stable within the active frame.
- Settled asserts on the cycle after the clamping Frame_Tick.
- Settled deasserts on the cycle after Show falls.
- Reset mid-slide returns all outputs to their reset values immediately.

## Structure
- Package banner_pkg holds:
  - the state enum (HIDDEN, SLIDING, SETTLED);
  - the 10-bit signed coordinate typedef;
  - a clog2-based address-width check function.
- Sub-module sprite_addr_gen holds the registered window hit and address computation. Inputs: position, size, pixel and enable. It is reusable by other overlays.
- banner_overlay holds the FSM, position register and blink timer.

## Test plan
All scenarios use default parameters: X_POS = 59, Y_FINAL = 85.
- Reset: assert Reset mid-frame -> is_obj = 0, Obj_address = 0, Settled = 0 asynchronously.
- Slide: Show = 1 held, 28 Frame_Ticks -> Y_TOP = 81, Settled = 0. Tick 29 -> Y_TOP = 85, Settled = 1 on the next cycle.
- Addressing when settled:
  - Pixel (59,85) -> is_obj = 1, address 0, one cycle later.
  - Pixel (261,115) -> address 6292.
  - Pixel (262,85) -> is_obj = 0.
  - Pixel (58,100) -> is_obj = 0.
- Clipping: after 1 tick (Y_TOP = -27), pixel (59,0) -> address 27*203 = 5481. Pixel (59,4) -> is_obj = 0.
- Blink: settled, Blink_En = 1 -> hits for 30 ticks, none for the next 30, then hits again. Drop Blink_En during the off phase -> hits resume the next cycle.
- Abort: Show = 0 mid-slide -> no hits the next cycle. Show = 1 with a coincident Frame_Tick -> Y_TOP = -31, unchanged on that tick.

Source files
------------

// File: rtl/banner_pkg.sv
// Shared types and elaboration helpers for the banner overlay and its sprite window.
package banner_pkg;

  typedef enum logic [1:0] {HIDDEN, SLIDING, SETTLED} state_e;

  typedef logic signed [9:0] coord_t;

  function automatic bit addr_w_ok(input int addr_w, input int width, input int height);
    return $clog2(width * height) <= addr_w;
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Registered rectangular window hit test and row-major ROM address for one sprite.
module sprite_addr_gen
  import banner_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  coord_t            pos_x_i,
  input  coord_t            pos_y_i,
  input  logic [9:0]        size_w_i,
  input  logic [9:0]        size_h_i,
  input  logic [8:0]        pixel_x_i,
  input  logic [8:0]        pixel_y_i,
  output logic              hit_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic signed [10:0] px, py, x0, y0, x1, y1;
  logic [10:0]        dist_x, dist_y;
  logic [21:0]        lin;
  logic               hit_d;
  logic [ADDR_W-1:0]  addr_d;

  // One guard bit so position + size never wraps in the compare.
  always_comb begin
    px     = {2'b00, pixel_x_i};
    py     = {2'b00, pixel_y_i};
    x0     = {pos_x_i[9], pos_x_i};
    y0     = {pos_y_i[9], pos_y_i};
    x1     = x0 + {1'b0, size_w_i};
    y1     = y0 + {1'b0, size_h_i};
    dist_x = px - x0;
    dist_y = py - y0;
    lin    = 22'(dist_y) * 22'(size_w_i) + 22'(dist_x);
    hit_d  = en_i && (px >= x0) && (px < x1) && (py >= y0) && (py < y1);
    addr_d = hit_d ? ADDR_W'(lin) : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_o  <= 1'b0;
      addr_o <= '0;
    end else begin
      hit_o  <= hit_d;
      addr_o <= addr_d;
    end
  end

endmodule

// File: rtl/banner_overlay.sv
// Animated banner window: slides in from above the screen, settles at its centre and
// optionally blinks; all motion advances on the per-frame tick.
module banner_overlay
  import banner_pkg::*;
#(
  parameter int WIDTH        = 203,
  parameter int HEIGHT       = 31,
  parameter int X_CENTER     = 160,
  parameter int Y_CENTER     = 100,
  parameter int ADDR_W       = 15,
  parameter int SLIDE_STEP   = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              show_i,
  input  logic              blink_en_i,
  input  logic              frame_tick_i,
  input  logic [8:0]        pixel_x_i,
  input  logic [8:0]        pixel_y_i,
  output logic              is_obj_o,
  output logic [ADDR_W-1:0] obj_address_o,
  output logic              settled_o
);

  localparam coord_t             X_POS     = coord_t'(X_CENTER - WIDTH / 2);
  localparam coord_t             Y_FINAL   = coord_t'(Y_CENTER - HEIGHT / 2);
  localparam coord_t             Y_START   = coord_t'(-HEIGHT);
  localparam logic signed [10:0] Y_FINAL11 = 11'(Y_CENTER - HEIGHT / 2);
  localparam logic signed [10:0] STEP      = 11'(SLIDE_STEP);
  localparam int                 CNT_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(BLINK_FRAMES - 1);

  if (!addr_w_ok(ADDR_W, WIDTH, HEIGHT)) begin : g_addr_w_check
    $error("banner_overlay: ADDR_W too small for WIDTH*HEIGHT");
  end

  state_e             state_q, state_d;
  coord_t             y_top_q, y_top_d;
  logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               visible_q, visible_d;
  logic               settled_q, settled_d;
  logic               win_en;
  logic signed [10:0] y_next;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= HIDDEN;
      y_top_q     <= Y_START;
      blink_cnt_q <= '0;
      visible_q   <= 1'b1;
      settled_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_top_q     <= y_top_d;
      blink_cnt_q <= blink_cnt_d;
      visible_q   <= visible_d;
      settled_q   <= settled_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    y_top_d     = y_top_q;
    blink_cnt_d = blink_cnt_q;
    visible_d   = visible_q;
    y_next      = {y_top_q[9], y_top_q} + STEP;
    if (!show_i) begin
      state_d     = HIDDEN;
      y_top_d     = Y_START;
      blink_cnt_d = '0;
      visible_d   = 1'b1;
    end else begin
      unique case (state_q)
        HIDDEN: begin
          // The frame tick coinciding with Show is deliberately ignored here.
          if (SLIDE_STEP == 0) begin
            state_d = SETTLED;
            y_top_d = Y_FINAL;
          end else begin
            state_d = SLIDING;
          end
        end
        SLIDING: begin
          if (frame_tick_i) begin
            if (y_next >= Y_FINAL11) begin
              y_top_d = Y_FINAL;
              state_d = SETTLED;
            end else begin
              y_top_d = y_next[9:0];
            end
          end
        end
        SETTLED: begin
          if (!blink_en_i) begin
            blink_cnt_d = '0;
            visible_d   = 1'b1;
          end else if (frame_tick_i) begin
            if (blink_cnt_q == CNT_LAST) begin
              blink_cnt_d = '0;
              visible_d   = ~visible_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = HIDDEN;
      endcase
    end
  end

  // Window enable follows the post-edge state so aborts and blink releases show up next cycle.
  always_comb begin
    win_en    = (state_d != HIDDEN) && visible_d;
    settled_d = (state_d == SETTLED);
  end

  assign settled_o = settled_q;

  sprite_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .rst_i     (reset_i),
    .en_i      (win_en),
    .pos_x_i   (X_POS),
    .pos_y_i   (y_top_d),
    .size_w_i  (10'(WIDTH)),
    .size_h_i  (10'(HEIGHT)),
    .pixel_x_i (pixel_x_i),
    .pixel_y_i (pixel_y_i),
    .hit_o     (is_obj_o),
    .addr_o    (obj_address_o)
  );

endmodule

// File: tb/tb_banner_overlay.sv
// Self-checking bench for banner_overlay against a frame-count based reference model.
module tb_banner_overlay;

  localparam int W       = 203;
  localparam int H       = 31;
  localparam int X_POS   = 160 - W / 2;
  localparam int Y_FINAL = 100 - H / 2;
  localparam int Y_START = -H;
  localparam int STEP    = 4;
  localparam int BF      = 30;

  logic        clk, rst, show, blink_en, tick;
  logic [8:0]  px, py;
  logic        is_obj, settled;
  logic [14:0] addr;

  int n_checks, n_fail;

  // Model: slide position from tick count, blink phase from settled-tick count.
  bit m_shown;
  int m_n, m_nb, m_px, m_py;

  banner_overlay dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .show_i        (show),
    .blink_en_i    (blink_en),
    .frame_tick_i  (tick),
    .pixel_x_i     (px),
    .pixel_y_i     (py),
    .is_obj_o      (is_obj),
    .obj_address_o (addr),
    .settled_o     (settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_ytop();
    int y;
    y = Y_START + STEP * m_n;
    return (y > Y_FINAL) ? Y_FINAL : y;
  endfunction

  function automatic bit exp_settled();
    return m_shown && (m_ytop() == Y_FINAL);
  endfunction

  function automatic bit exp_hit();
    int yt;
    yt = m_ytop();
    return m_shown && (((m_nb / BF) % 2) == 0) && (m_px >= X_POS) && (m_px < X_POS + W)
           && (m_py >= yt) && (m_py < yt + H);
  endfunction

  function automatic int exp_addr();
    return exp_hit() ? (m_px - X_POS) + (m_py - m_ytop()) * W : 0;
  endfunction

  task automatic model_clear();
    m_shown = 0; m_n = 0; m_nb = 0;
  endtask

  task automatic step();
    @(posedge clk);
    if (!show) begin
      model_clear();
    end else if (!m_shown) begin
      m_shown = 1;
    end else if (exp_settled()) begin
      if (!blink_en) m_nb = 0;
      else if (tick) m_nb++;
    end else if (tick) begin
      m_n++;
    end
    m_px = int'(px);
    m_py = int'(py);
    #1;
  endtask

  task automatic frame();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; show = 1'b0; blink_en = 1'b0; tick = 1'b0; px = '0; py = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (is_obj !== 1'b0 || addr !== 15'd0 || settled !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: is_obj=%b addr=%0d settled=%b, required 0/0/0", is_obj, addr, settled);
    end
    rst = 1'b0;
    show = 1'b1; px = 9'd100; py = 9'd100;
    step();
    repeat (29) frame();
    n_checks++;
    if (is_obj !== exp_hit() || settled !== exp_settled() || is_obj !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_presettle: is_obj=%b settled=%b, required %b/%b", is_obj, settled, exp_hit(), exp_settled());
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (is_obj !== 1'b0 || addr !== 15'd0 || settled !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: is_obj=%b addr=%0d settled=%b, required 0/0/0", is_obj, addr, settled);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; show = 1'b0;
    model_clear();
    step();
  endtask

  task automatic test_slide();
    show = 1'b0; blink_en = 1'b0; px = 9'd59; py = 9'd81;
    step();
    show = 1'b1;
    step();
    for (int f = 1; f <= 29; f++) begin
      frame();
      n_checks++;
      if (settled !== exp_settled() || is_obj !== exp_hit() || addr !== 15'(exp_addr())) begin
        n_fail++;
        $display("FAIL slide_frame%0d: settled=%b is_obj=%b addr=%0d, required %b/%b/%0d",
                 f, settled, is_obj, addr, exp_settled(), exp_hit(), exp_addr());
      end
      if (f == 28) begin
        n_checks++;
        if (settled !== 1'b0 || is_obj !== 1'b1 || addr !== 15'd0) begin
          n_fail++;
          $display("FAIL slide_at81: settled=%b is_obj=%b addr=%0d, required 0/1/0", settled, is_obj, addr);
        end
        py = 9'd80;
        step();
        n_checks++;
        if (is_obj !== 1'b0) begin
          n_fail++;
          $display("FAIL slide_above81: is_obj=%b, required 0", is_obj);
        end
        py = 9'd81;
      end
    end
    n_checks++;
    if (settled !== 1'b1) begin
      n_fail++;
      $display("FAIL slide_settled: settled=%b, required 1", settled);
    end
  endtask

  task automatic test_addressing();
    int tx[4] = '{59, 261, 262, 58};
    int ty[4] = '{85, 115, 85, 100};
    bit th[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int ta[4] = '{0, 6292, 0, 0};
    for (int i = 0; i < 4; i++) begin
      px = 9'(tx[i]); py = 9'(ty[i]);
      step();
      n_checks++;
      if (is_obj !== th[i] || addr !== 15'(ta[i]) || is_obj !== exp_hit() || addr !== 15'(exp_addr())) begin
        n_fail++;
        $display("FAIL addr_pix(%0d,%0d): is_obj=%b addr=%0d, required %b/%0d",
                 tx[i], ty[i], is_obj, addr, th[i], ta[i]);
      end
    end
  endtask

  task automatic test_clipping();
    show = 1'b0;
    step();
    show = 1'b1; px = 9'd59; py = 9'd0;
    step();
    frame();
    step();
    n_checks++;
    if (is_obj !== 1'b1 || addr !== 15'd5481 || addr !== 15'(exp_addr())) begin
      n_fail++;
      $display("FAIL clip_row0: is_obj=%b addr=%0d, required 1/5481", is_obj, addr);
    end
    py = 9'd4;
    step();
    n_checks++;
    if (is_obj !== 1'b0 || addr !== 15'd0 || is_obj !== exp_hit()) begin
      n_fail++;
      $display("FAIL clip_row4: is_obj=%b addr=%0d, required 0/0", is_obj, addr);
    end
  endtask

  task automatic test_blink();
    px = 9'd100; py = 9'd100;
    while (!exp_settled()) frame();
    blink_en = 1'b1;
    step();
    for (int f = 1; f <= 90; f++) begin
      frame();
      n_checks++;
      if (is_obj !== exp_hit() || is_obj !== bit'(((f / BF) % 2) == 0)) begin
        n_fail++;
        $display("FAIL blink_tick%0d: is_obj=%b, required %b", f, is_obj, exp_hit());
      end
    end
    blink_en = 1'b0;
    step();
    n_checks++;
    if (is_obj !== 1'b1 || is_obj !== exp_hit()) begin
      n_fail++;
      $display("FAIL blink_release: is_obj=%b, required 1", is_obj);
    end
  endtask

  task automatic test_abort();
    show = 1'b0;
    step();
    show = 1'b1; px = 9'd59; py = 9'd0;
    step();
    repeat (5) frame();
    n_checks++;
    if (is_obj !== 1'b1 || addr !== 15'(11 * W) || addr !== 15'(exp_addr())) begin
      n_fail++;
      $display("FAIL abort_midslide: is_obj=%b addr=%0d, required 1/%0d", is_obj, addr, 11 * W);
    end
    show = 1'b0;
    step();
    n_checks++;
    if (is_obj !== 1'b0 || settled !== 1'b0 || is_obj !== exp_hit()) begin
      n_fail++;
      $display("FAIL abort_hide: is_obj=%b settled=%b, required 0/0", is_obj, settled);
    end
    show = 1'b1; tick = 1'b1;
    step();
    tick = 1'b0;
    n_checks++;
    if (is_obj !== 1'b0 || is_obj !== exp_hit()) begin
      n_fail++;
      $display("FAIL abort_show_tick: is_obj=%b, required 0", is_obj);
    end
    step();
    frame();
    n_checks++;
    if (is_obj !== 1'b1 || addr !== 15'd5481) begin
      n_fail++;
      $display("FAIL abort_first_move: is_obj=%b addr=%0d, required 1/5481", is_obj, addr);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) show = ~show;
      else if (!show && $urandom_range(0, 3) == 0) show = 1'b1;
      if ($urandom_range(0, 59) == 0) blink_en = ~blink_en;
      tick = ($urandom_range(0, 3) == 0);
      px = 9'($urandom_range(40, 280));
      py = 9'($urandom_range(0, 140));
      step();
      n_checks++;
      if (is_obj !== exp_hit() || addr !== 15'(exp_addr()) || settled !== exp_settled()) begin
        n_fail++;
        $display("FAIL random_cyc%0d: is_obj=%b addr=%0d settled=%b, required %b/%0d/%b",
                 c, is_obj, addr, settled, exp_hit(), exp_addr(), exp_settled());
      end
    end
    tick = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_clear();
    m_px = 0; m_py = 0;
    test_reset();
    test_slide();
    test_addressing();
    test_clipping();
    test_blink();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
